mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the instruction-fetch port of stage F and the data port of stage M in the combined ARM/RISC-V pipeline. It serialises requests onto a variable-latency memory handshake and returns per-requester ready pulses that the pipeline uses as stall sources. Data accesses win by default, and a streak limit prevents fetch starvation.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while a fetch is pending. Range 1..15.
- `clk` in 1: clock. Everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request. Must be held until `i_ready`.
- `i_addr` in 32: fetch address.
- `i_rdata` out 32: fetch data. Valid while `i_ready` is high.
- `i_ready` out 1: one-cycle fetch completion pulse.
- `d_req` in 1: data request. Must be held until `d_ready`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data. Valid while `d_ready` is high.
- `d_ready` out 1: one-cycle data completion pulse.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data. Valid with `mem_ack`.
- `mem_ack` in 1: memory completion. Earliest arrival is the first cycle `mem_req` is high.

## Operation
- States:
  - IDLE: no transaction.
  - BUSY_I / BUSY_D: memory transaction in flight.
  - RESP_I / RESP_D: ready pulse cycle.
- Grant pick, evaluated in IDLE and RESP_x:
  - Only `d_req`: grant D.
  - Only `i_req`: grant I.
  - Both: grant D, unless `streak == MAX_D_STREAK`, in which case grant I.
  - In RESP_x, requester x is masked; only the other side may be granted. With no grant, go to IDLE.
- On a grant to x, latch the address, `we` and wdata into the `mem_*` registers and enter BUSY_x.
  - Fetch grants: `mem_we` = 0, `mem_wdata` = 0.
- BUSY_x with `mem_ack`:
  - `mem_req` drops.
  - On reads, `mem_rdata` is latched into `x_rdata`.
  - Enter RESP_x, where `x_ready` = 1 for exactly one cycle.
- Writes leave `d_rdata` unchanged.
- Streak counter (4 bits):
  - D grant with `i_req` high: +1, saturating at `MAX_D_STREAK`.
  - D grant with `i_req` low: cleared.
  - I grant: cleared.
- Protocol violations:
  - `mem_ack` outside BUSY_x is ignored.
  - A requester dropping `req` mid-transaction does not abort it; the ready pulse still occurs.
  - Request inputs are not re-sampled after the grant.
- Reset:
  - Every output goes to 0 and `streak` to 0; state goes to IDLE.
  - A transaction in flight is abandoned: `mem_req` is low on the cycle after the reset edge, and no ready pulse is issued.
  - A late `mem_ack` is then ignored.

## Timing
- Grant taken at edge 0, with the request visible in the preceding cycle. `mem_req` is high from cycle 1.
- `mem_ack` in cycle k gives `x_ready` in cycle k+1.
- Minimum latency: request seen → ready = 2 cycles, with `mem_ack` arriving in the first `mem_req` cycle.
- A back-to-back request from the same requester is not granted in its own RESP cycle. Earliest re-grant is from IDLE, one cycle later.
- Alternating I/D requests can be granted directly from RESP, giving zero IDLE cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `combi_pkg`:
  - `arb_state_t` enum (IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D).
  - `arb_sel_t` (SEL_I, SEL_D).
- Pick logic stays inline; no sub-module is warranted.
- Streak width is a localparam, sized for `MAX_D_STREAK` ≤ 15.

## Test plan
- Lone fetch, `i_addr` = 0x100, `mem_ack` in the first `mem_req` cycle with `mem_rdata` = 0xE3A01005 → `mem_addr` = 0x100, `mem_we` = 0, and `i_ready` pulses once with `i_rdata` = 0xE3A01005, two cycles after the grant.
- Simultaneous `d_req` write (`d_addr` = 0x2000, `d_wdata` = 0xDEADBEEF) and `i_req` → D is served first (`mem_we` = 1, `mem_wdata` = 0xDEADBEEF), then I is granted directly from RESP_D. `d_rdata` is unchanged.
- `d_req` held continuously with `i_req` pending, `MAX_D_STREAK` = 4 → exactly 4 D grants, then 1 I grant, then D resumes with `streak` = 0.
- Memory latency of 5 cycles (`mem_ack` in the 5th `mem_req` cycle) → `mem_req` is high for exactly 5 cycles, `mem_addr` stays stable throughout, and the ready pulse comes on the 6th cycle.
- `rst` asserted in the 3rd BUSY_D cycle, then `mem_ack` one cycle later → all outputs are 0 after the edge, no `d_ready` is issued, and the ack is ignored.
- Spurious `mem_ack` in IDLE, and `i_req` held through RESP_I → no ready pulse from the spurious ack, and I is re-granted only from IDLE (1-cycle gap).

Source files
------------

// File: rtl/combi_pkg.sv
// Shared types for the combined ARM/RISC-V pipeline memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_sel_t   : which requester a grant goes to
//   STREAK_W    : width of the consecutive-data-grant counter (MAX_D_STREAK <= 15)
package combi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP_I,
      RESP_D
   } arb_state_t;

   typedef enum logic {
      SEL_I,
      SEL_D
   } arb_sel_t;

   localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory handshake seen by mem_arbiter.
//   Fetch  : i_req, i_addr (in)  / i_rdata, i_ready (out)
//   Data   : d_req, d_we, d_addr, d_wdata (in) / d_rdata, d_ready (out)
//   Memory : mem_req, mem_we, mem_addr, mem_wdata (out) / mem_rdata, mem_ack (in)
// Modport slave is the arbiter's view; master is the pipeline + memory side.
interface mem_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  i_req, i_addr,
      output i_rdata, i_ready,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output i_req, i_addr,
      input  i_rdata, i_ready,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the stage-F fetch port and the stage-M data port onto one
// single-ported memory with a variable-latency req/ack handshake.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch port, data port, memory port)
// Data wins by default; after MAX_D_STREAK consecutive data grants with a
// fetch pending, the fetch is granted. All outputs come straight from flops.
module mem_arbiter
   import combi_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

   arb_state_t          stateQ, stateNext;
   logic [STREAK_W-1:0] streakQ, streakNext;
   logic                memReqQ, memReqNext;
   logic                memWeQ, memWeNext;
   logic [31:0]         memAddrQ, memAddrNext;
   logic [31:0]         memWdataQ, memWdataNext;
   logic [31:0]         iRdataQ, iRdataNext;
   logic [31:0]         dRdataQ, dRdataNext;
   logic                iReadyQ, iReadyNext;
   logic                dReadyQ, dReadyNext;

   logic                canI, canD, pickValid;
   arb_sel_t            pick;

   // A requester in its own ready cycle is masked so it cannot be re-granted
   // before it has seen the pulse.
   always_comb begin
      canI = 1'b0;
      canD = 1'b0;
      if (stateQ == IDLE || stateQ == RESP_D) canI = bus.i_req;
      if (stateQ == IDLE || stateQ == RESP_I) canD = bus.d_req;
      pickValid = canI || canD;
      pick      = (canD && !(canI && streakQ == MAX_STREAK)) ? SEL_D : SEL_I;
   end

   always_comb begin
      stateNext    = stateQ;
      streakNext   = streakQ;
      memReqNext   = memReqQ;
      memWeNext    = memWeQ;
      memAddrNext  = memAddrQ;
      memWdataNext = memWdataQ;
      iRdataNext   = iRdataQ;
      dRdataNext   = dRdataQ;
      iReadyNext   = 1'b0;
      dReadyNext   = 1'b0;

      unique case (stateQ)
         IDLE, RESP_I, RESP_D: begin
            stateNext = IDLE;
            if (pickValid) begin
               memReqNext = 1'b1;
               if (pick == SEL_D) begin
                  stateNext    = BUSY_D;
                  memWeNext    = bus.d_we;
                  memAddrNext  = bus.d_addr;
                  memWdataNext = bus.d_wdata;
                  // Raw i_req: a fetch held through its own ready cycle still counts as waiting.
                  if (bus.i_req) begin
                     streakNext = (streakQ == MAX_STREAK) ? streakQ : streakQ + 1'b1;
                  end else begin
                     streakNext = '0;
                  end
               end else begin
                  stateNext    = BUSY_I;
                  memWeNext    = 1'b0;
                  memAddrNext  = bus.i_addr;
                  memWdataNext = '0;
                  streakNext   = '0;
               end
            end
         end
         BUSY_I: begin
            if (bus.mem_ack) begin
               memReqNext = 1'b0;
               iRdataNext = bus.mem_rdata;
               iReadyNext = 1'b1;
               stateNext  = RESP_I;
            end
         end
         BUSY_D: begin
            if (bus.mem_ack) begin
               memReqNext = 1'b0;
               if (!memWeQ) dRdataNext = bus.mem_rdata;
               dReadyNext = 1'b1;
               stateNext  = RESP_D;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= IDLE;
         streakQ   <= '0;
         memReqQ   <= 1'b0;
         memWeQ    <= 1'b0;
         memAddrQ  <= '0;
         memWdataQ <= '0;
         iRdataQ   <= '0;
         dRdataQ   <= '0;
         iReadyQ   <= 1'b0;
         dReadyQ   <= 1'b0;
      end else begin
         stateQ    <= stateNext;
         streakQ   <= streakNext;
         memReqQ   <= memReqNext;
         memWeQ    <= memWeNext;
         memAddrQ  <= memAddrNext;
         memWdataQ <= memWdataNext;
         iRdataQ   <= iRdataNext;
         dRdataQ   <= dRdataNext;
         iReadyQ   <= iReadyNext;
         dReadyQ   <= dReadyNext;
      end
   end

   assign bus.mem_req   = memReqQ;
   assign bus.mem_we    = memWeQ;
   assign bus.mem_addr  = memAddrQ;
   assign bus.mem_wdata = memWdataQ;
   assign bus.i_rdata   = iRdataQ;
   assign bus.i_ready   = iReadyQ;
   assign bus.d_rdata   = dRdataQ;
   assign bus.d_ready   = dReadyQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory against a
// transaction-level model of who is being served.
module tb_mem_arbiter;

   localparam int MAXD = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_D_STREAK(MAXD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
   endfunction

   // ---------------- reference model ----------------
   // who: 0 = memory idle, 1 = serving fetch, 2 = serving data.
   bit          modelValid = 1'b0;
   int          who, streak, w;
   logic        mReq, mWe, mIReady, mDReady, lastI, lastD, wantI, wantD;
   logic [31:0] mAddr, mWdata, mIRdata, mDRdata;

   always @(posedge clk) begin
      if (rst) begin
         modelValid = 1'b1;
         who = 0; streak = 0;
         mReq = 0; mWe = 0; mAddr = 0; mWdata = 0;
         mIRdata = 0; mDRdata = 0; mIReady = 0; mDReady = 0;
      end else begin
         w = who;
         lastI = mIReady;
         lastD = mDReady;
         mIReady = 0;
         mDReady = 0;
         if (w != 0) begin
            if (bus.mem_ack) begin
               mReq = 0;
               who  = 0;
               if (w == 1) begin
                  mIRdata = bus.mem_rdata;
                  mIReady = 1;
               end else begin
                  if (!mWe) mDRdata = bus.mem_rdata;
                  mDReady = 1;
               end
            end
         end else begin
            wantI = bus.i_req && !lastI;
            wantD = bus.d_req && !lastD;
            if (wantD && !(wantI && streak == MAXD)) begin
               who = 2; mReq = 1; mWe = bus.d_we; mAddr = bus.d_addr; mWdata = bus.d_wdata;
               if (bus.i_req) streak = (streak < MAXD) ? streak + 1 : streak;
               else streak = 0;
            end else if (wantI) begin
               who = 1; mReq = 1; mWe = 0; mAddr = bus.i_addr; mWdata = 0;
               streak = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         chk("m_mem_req",   32'(bus.mem_req), 32'(mReq));
         chk("m_mem_we",    32'(bus.mem_we),  32'(mWe));
         chk("m_mem_addr",  bus.mem_addr,     mAddr);
         chk("m_mem_wdata", bus.mem_wdata,    mWdata);
         chk("m_i_ready",   32'(bus.i_ready), 32'(mIReady));
         chk("m_i_rdata",   bus.i_rdata,      mIRdata);
         chk("m_d_ready",   32'(bus.d_ready), 32'(mDReady));
         chk("m_d_rdata",   bus.d_rdata,      mDRdata);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_mem_req"},   32'(bus.mem_req), 32'h0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),  32'h0);
      chk({tag, "_mem_addr"},  bus.mem_addr,     32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,    32'h0);
      chk({tag, "_i_ready"},   32'(bus.i_ready), 32'h0);
      chk({tag, "_i_rdata"},   bus.i_rdata,      32'h0);
      chk({tag, "_d_ready"},   32'(bus.d_ready), 32'h0);
      chk({tag, "_d_rdata"},   bus.d_rdata,      32'h0);
   endtask

   int nGrants;
   bit gotD [16];
   bit expSeq [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      rst = 1'b1;
      bus.i_req = 0; bus.i_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      repeat (3) tick;
      chkAllZero("reset");
      rst = 1'b0;

      // Lone fetch with single-cycle memory.
      bus.i_req = 1; bus.i_addr = 32'h100;
      tick;
      chk("t1_mem_req",  32'(bus.mem_req), 32'h1);
      chk("t1_mem_addr", bus.mem_addr,     32'h100);
      chk("t1_mem_we",   32'(bus.mem_we),  32'h0);
      bus.mem_ack = 1; bus.mem_rdata = 32'hE3A01005;
      tick;
      chk("t1_i_ready",  32'(bus.i_ready), 32'h1);
      chk("t1_i_rdata",  bus.i_rdata,      32'hE3A01005);
      chk("t1_mem_req_drop", 32'(bus.mem_req), 32'h0);
      bus.mem_ack = 0; bus.i_req = 0;
      tick;
      chk("t1_i_ready_once", 32'(bus.i_ready), 32'h0);

      // Simultaneous write and fetch: data first, fetch straight from RESP_D.
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
      bus.i_req = 1; bus.i_addr = 32'h104;
      tick;
      chk("t2_mem_we",    32'(bus.mem_we), 32'h1);
      chk("t2_mem_addr",  bus.mem_addr,    32'h2000);
      chk("t2_mem_wdata", bus.mem_wdata,   32'hDEADBEEF);
      bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
      tick;
      chk("t2_d_ready", 32'(bus.d_ready), 32'h1);
      chk("t2_d_rdata_kept", bus.d_rdata, 32'h0);
      bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
      tick;
      chk("t2_i_granted_from_resp", 32'(bus.mem_req), 32'h1);
      chk("t2_i_addr",  bus.mem_addr,     32'h104);
      chk("t2_i_we",    32'(bus.mem_we),  32'h0);
      chk("t2_i_wdata", bus.mem_wdata,    32'h0);
      bus.mem_ack = 1; bus.mem_rdata = 32'hAAAA5555;
      tick;
      chk("t2_i_ready", 32'(bus.i_ready), 32'h1);
      chk("t2_i_rdata", bus.i_rdata,      32'hAAAA5555);
      chk("t2_d_rdata_final", bus.d_rdata, 32'h0);
      bus.mem_ack = 0; bus.i_req = 0;
      tick; tick;

      // Streak limit: fetch pending at every IDLE pick, data held throughout.
      nGrants = 0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4000;
      bus.i_req = 1; bus.i_addr = 32'h300;
      for (int c = 0; c < 100 && nGrants < 11; c++) begin
         tick;
         if (bus.mem_req) begin
            gotD[nGrants] = (bus.mem_addr == 32'h4000);
            nGrants++;
            bus.mem_ack = 1; bus.mem_rdata = hash(bus.mem_addr);
         end else begin
            bus.mem_ack = 0;
         end
         if (bus.mem_req && bus.mem_addr == 32'h300) bus.i_req = 1;
         else if (bus.mem_req || bus.i_ready || bus.d_ready) bus.i_req = 0;
         else bus.i_req = 1;
      end
      tick;
      bus.mem_ack = 0; bus.i_req = 0; bus.d_req = 0;
      tick; tick;
      chk("t3_grant_count", nGrants, 11);
      for (int g = 0; g < 11; g++) chk($sformatf("t3_grant%0d_isD", g), 32'(gotD[g]), 32'(expSeq[g]));

      // Five-cycle memory latency.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h5000;
      for (int k = 1; k <= 5; k++) begin
         tick;
         chk($sformatf("t4_mem_req_c%0d", k),  32'(bus.mem_req), 32'h1);
         chk($sformatf("t4_mem_addr_c%0d", k), bus.mem_addr,     32'h5000);
         chk($sformatf("t4_no_ready_c%0d", k), 32'(bus.d_ready), 32'h0);
         if (k == 5) begin
            bus.mem_ack = 1; bus.mem_rdata = hash(32'h5000);
         end
      end
      tick;
      chk("t4_d_ready", 32'(bus.d_ready), 32'h1);
      chk("t4_d_rdata", bus.d_rdata,      hash(32'h5000));
      chk("t4_mem_req_drop", 32'(bus.mem_req), 32'h0);
      bus.mem_ack = 0; bus.d_req = 0;
      tick;

      // Reset in the third BUSY_D cycle, then a late ack.
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h6000; bus.d_wdata = 32'hCAFEF00D;
      tick; tick; tick;
      chk("t5_busy3", 32'(bus.mem_req), 32'h1);
      rst = 1'b1;
      tick;
      rst = 1'b0; bus.d_req = 0; bus.d_we = 0;
      chkAllZero("t5_after_rst");
      bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF;
      tick;
      chk("t5_late_ack_d_ready", 32'(bus.d_ready), 32'h0);
      chk("t5_late_ack_mem_req", 32'(bus.mem_req), 32'h0);
      bus.mem_ack = 0;
      tick;
      chk("t5_no_ready", 32'(bus.d_ready), 32'h0);

      // Spurious ack in IDLE, then a fetch held through its ready cycle.
      bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
      tick;
      bus.mem_ack = 0;
      tick;
      chk("t6_spur_i_ready", 32'(bus.i_ready), 32'h0);
      chk("t6_spur_d_ready", 32'(bus.d_ready), 32'h0);
      chk("t6_spur_i_rdata", bus.i_rdata,      32'h0);
      bus.i_req = 1; bus.i_addr = 32'h700;
      tick;
      chk("t6_grant", 32'(bus.mem_req), 32'h1);
      bus.mem_ack = 1; bus.mem_rdata = hash(32'h700);
      tick;
      chk("t6_i_ready", 32'(bus.i_ready), 32'h1);
      bus.mem_ack = 0;
      tick;
      chk("t6_gap_mem_req", 32'(bus.mem_req), 32'h0);
      chk("t6_gap_i_ready", 32'(bus.i_ready), 32'h0);
      tick;
      chk("t6_regrant", 32'(bus.mem_req), 32'h1);
      chk("t6_regrant_addr", bus.mem_addr, 32'h700);
      bus.mem_ack = 1;
      tick;
      chk("t6_i_ready2", 32'(bus.i_ready), 32'h1);
      bus.mem_ack = 0; bus.i_req = 0;
      tick;

      // Randomized traffic with random latency, spurious acks and resets.
      for (int c = 0; c < 4000; c++) begin
         tick;
         rst = ($urandom_range(299) == 0);
         if (bus.i_ready) chk("rnd_i_data", bus.i_rdata, hash(bus.i_addr));
         if (!bus.i_req || bus.i_ready) begin
            if ($urandom_range(2) == 0) begin
               bus.i_req = 1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
            end else begin
               bus.i_req = 0;
            end
         end
         if (bus.d_ready && !bus.d_we) chk("rnd_d_data", bus.d_rdata, hash(bus.d_addr));
         if (!bus.d_req || bus.d_ready) begin
            if ($urandom_range(1) == 0) begin
               bus.d_req = 1; bus.d_we = 1'($urandom_range(1));
               bus.d_addr = $urandom & 32'hFFFF_FFFC; bus.d_wdata = $urandom;
            end else begin
               bus.d_req = 0;
            end
         end
         if (bus.mem_req) begin
            if ($urandom_range(2) == 0) begin
               bus.mem_ack = 1; bus.mem_rdata = hash(bus.mem_addr);
            end else begin
               bus.mem_ack = 0; bus.mem_rdata = $urandom;
            end
         end else begin
            bus.mem_ack = ($urandom_range(7) == 0);
            bus.mem_rdata = $urandom;
         end
      end
      rst = 0; bus.i_req = 0; bus.d_req = 0; bus.mem_ack = 0;
      repeat (3) tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
